mem_bigreg_ctrl: RTL

Parametrised assembler for PS-written big registers in the AXI memory map (seed batch, channel mux, sample discriminator config). It sits between the mem-map write path and an RTL consumer and collects `NUM_WORDS` word writes into a staging register. When the PS writes the valid index, it commits the staged value atomically to the consumer through a valid/ready handshake and reports a response code per write. One instance serves one big register at any base index, width or word size.

---
 rtl/mem_bigreg_if.sv | 28 ++
 rtl/mem_bigreg_ctrl.sv | 68 ++++++
 2 files changed

// File: rtl/mem_bigreg_if.sv
// mem_bigreg_if: mem-map write bus and consumer handshake of one big register
interface mem_bigreg_if #(
  parameter int WORD_WIDTH    = 16,
  parameter int REG_WIDTH     = 256,
  parameter int ID_WIDTH      = 8,
  parameter int ERR_CNT_WIDTH = 8
);
  localparam int NUM_WORDS = REG_WIDTH / WORD_WIDTH;
  logic                     wr_en;
  logic [ID_WIDTH-1:0]      wr_id;
  logic [WORD_WIDTH-1:0]    wr_data;
  logic [REG_WIDTH-1:0]     reg_out;
  logic                     reg_valid;
  logic                     rtl_ready;
  logic [NUM_WORDS-1:0]     fresh;
  logic                     fresh_clr;
  logic [1:0]               resp;
  logic                     resp_valid;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;
  modport master (
    output wr_en, wr_id, wr_data, rtl_ready,
    input  reg_out, reg_valid, fresh, fresh_clr, resp, resp_valid, err_cnt
  );
  modport slave (
    input  wr_en, wr_id, wr_data, rtl_ready,
    output reg_out, reg_valid, fresh, fresh_clr, resp, resp_valid, err_cnt
  );
endinterface

// File: rtl/mem_bigreg_ctrl.sv
// mem_bigreg_ctrl: stages NUM_WORDS mem-map writes and commits them atomically on the valid index.
// Define BIGREG_PARTIAL_COMMIT_EN to let an incomplete fresh mask commit only its fresh words.
module mem_bigreg_ctrl #(
  parameter int WORD_WIDTH    = 16,
  parameter int REG_WIDTH     = 256,
  parameter int ID_WIDTH      = 8,
  parameter int BASE_ID       = 33,
  parameter int ERR_CNT_WIDTH = 8
) (
  input logic clk,
  input logic rst,
  mem_bigreg_if.slave bus
);
  localparam int NUM_WORDS = REG_WIDTH / WORD_WIDTH;
  localparam logic [ID_WIDTH-1:0] BASE = ID_WIDTH'(BASE_ID);
  localparam logic [ID_WIDTH-1:0] VID  = ID_WIDTH'(BASE_ID + NUM_WORDS);
  typedef enum logic {IDLE, PENDING} state_t;
  state_t state;
  logic [REG_WIDTH-1:0] stg, fmask;
  logic [ID_WIDTH-1:0] idx;
  logic [NUM_WORDS-1:0] fresh_n;
  logic is_data, is_valid, all_fresh, can_go, commit, reject;
  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_mask
    assign fmask[i*WORD_WIDTH +: WORD_WIDTH] = {WORD_WIDTH{bus.fresh[i]}};
  end
  always_comb begin
    idx       = bus.wr_id - BASE;
    is_data   = bus.wr_en && bus.wr_id >= BASE && bus.wr_id < VID;
    is_valid  = bus.wr_en && bus.wr_id == VID;
    all_fresh = &bus.fresh;
    can_go    = is_valid && (state == IDLE || bus.rtl_ready);
`ifdef BIGREG_PARTIAL_COMMIT_EN
    commit    = can_go;
`else
    commit    = can_go && all_fresh;
`endif
    reject    = is_valid && !commit;
    fresh_n   = (commit ? '0 : bus.fresh) | (is_data ? NUM_WORDS'(1) << idx : '0);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      stg            <= '0;
      bus.reg_out    <= '0;
      bus.reg_valid  <= 1'b0;
      bus.fresh      <= '0;
      bus.fresh_clr  <= 1'b0;
      bus.resp       <= 2'b00;
      bus.resp_valid <= 1'b0;
      bus.err_cnt    <= '0;
    end else begin
      bus.resp_valid <= is_data || is_valid;
      bus.fresh_clr  <= commit;
      bus.fresh      <= fresh_n;
      if (is_data || is_valid)
        bus.resp <= reject ? 2'b10 : (commit && !all_fresh) ? 2'b01 : 2'b00;
      if (reject && !(&bus.err_cnt))
        bus.err_cnt <= bus.err_cnt + 1'b1;
      // stale words keep their committed value; with a full mask this is a plain copy
      if (commit)
        bus.reg_out <= (stg & fmask) | (bus.reg_out & ~fmask);
      for (int k = 0; k < NUM_WORDS; k++)
        if (is_data && idx == ID_WIDTH'(k)) stg[k*WORD_WIDTH +: WORD_WIDTH] <= bus.wr_data;
      state         <= commit ? PENDING : bus.rtl_ready ? IDLE : state;
      bus.reg_valid <= commit || (state == PENDING && !bus.rtl_ready);
    end
  end
endmodule
